// File: rtl/dzcpu_mem_responder.sv
// Memory-side responder for the dzcpu MCU bus: boot-ROM overlay, work RAM with echo,
// high RAM, interrupt/timer registers; everything else is forwarded to an external port.
module dzcpu_mem_responder #(
  parameter int unsigned WRAM_AW = 13,
  parameter int unsigned BOOT_AW = 8
) (
  input  logic               iClock,
  input  logic               iReset_n,
  input  logic [15:0]        iMCUAddr,
  input  logic               iMCUwe,
  input  logic [7:0]         iMCUData,
  output logic [7:0]         oMCUData,
  output logic [BOOT_AW-1:0] oBootAddr,
  input  logic [7:0]         iBootData,
  output logic [15:0]        oExtAddr,
  output logic               oExtRe,
  output logic               oExtWe,
  output logic [7:0]         oExtData,
  input  logic [7:0]         iExtData,
  output logic [4:0]         oIntFlags
);

  localparam int unsigned WramDepth = 1 << WRAM_AW;

  logic [7:0] wram [WramDepth];
  logic [7:0] hram [127];

  logic [15:0] cnt_q, cnt_d;
  logic [7:0]  tima_q, tima_d;
  logic [7:0]  tma_q, tma_d;
  logic [2:0]  tac_q, tac_d;
  logic [4:0]  if_q, if_d;
  logic [7:0]  ie_q, ie_d;
  logic        boot_q, boot_d;
  logic [7:0]  rdata_q, rdata_d;

  logic sel_boot, sel_wram, sel_unus, sel_div, sel_tima, sel_tma, sel_tac;
  logic sel_if, sel_bctl, sel_hram, sel_ie, sel_int, sel_ext;
  logic tick, ovf, wr_tima;

  logic [WRAM_AW-1:0] wram_idx;
  logic [6:0]         hram_idx;

  // Selected bit of the divider gated by the timer enable; TIMA counts its falling edges.
  function automatic logic timer_tap(input logic [15:0] c, input logic [2:0] t);
    logic b;
    case (t[1:0])
      2'b00:   b = c[9];
      2'b01:   b = c[3];
      2'b10:   b = c[5];
      default: b = c[7];
    endcase
    return b & t[2];
  endfunction

  assign wram_idx  = iMCUAddr[WRAM_AW-1:0];
  assign hram_idx  = iMCUAddr[6:0];
  assign oBootAddr = iMCUAddr[BOOT_AW-1:0];
  assign oExtAddr  = iMCUAddr;
  assign oExtData  = iMCUData;
  assign oMCUData  = rdata_q;
  assign oIntFlags = if_q & ie_q[4:0];

  // Address decode; the boot overlay shadows the cartridge only while boot_q is set.
  always_comb begin
    sel_boot = boot_q && (iMCUAddr[15:8] == 8'h00);
    sel_wram = (iMCUAddr >= 16'hC000) && (iMCUAddr < 16'hFE00);
    sel_unus = (iMCUAddr >= 16'hFEA0) && (iMCUAddr <= 16'hFEFF);
    sel_div  = (iMCUAddr == 16'hFF04);
    sel_tima = (iMCUAddr == 16'hFF05);
    sel_tma  = (iMCUAddr == 16'hFF06);
    sel_tac  = (iMCUAddr == 16'hFF07);
    sel_if   = (iMCUAddr == 16'hFF0F);
    sel_bctl = (iMCUAddr == 16'hFF50);
    sel_hram = (iMCUAddr >= 16'hFF80) && (iMCUAddr <= 16'hFFFE);
    sel_ie   = (iMCUAddr == 16'hFFFF);
    sel_int  = sel_wram | sel_unus | sel_div | sel_tima | sel_tma | sel_tac |
               sel_if | sel_bctl | sel_hram | sel_ie;
    sel_ext  = !sel_boot && !sel_int;
    oExtRe   = !iMCUwe && sel_ext;
    // Boot-region writes go to the cartridge MBC even while the ROM is overlaid.
    oExtWe   = iMCUwe && (sel_ext || sel_boot);
  end

  // Read-data mux, captured into rdata_q on cycles without a write strobe.
  always_comb begin
    rdata_d = 8'hFF;
    if (sel_boot)      rdata_d = iBootData;
    else if (sel_wram) rdata_d = wram[wram_idx];
    else if (sel_unus) rdata_d = 8'hFF;
    else if (sel_div)  rdata_d = cnt_q[15:8];
    else if (sel_tima) rdata_d = tima_q;
    else if (sel_tma)  rdata_d = tma_q;
    else if (sel_tac)  rdata_d = {5'b11111, tac_q};
    else if (sel_if)   rdata_d = {3'b111, if_q};
    else if (sel_bctl) rdata_d = 8'hFF;
    else if (sel_hram) rdata_d = hram[hram_idx];
    else if (sel_ie)   rdata_d = ie_q;
    else               rdata_d = iExtData;
  end

  // Register next-state: timer, interrupt flags and boot overlay flag.
  always_comb begin
    wr_tima = iMCUwe && sel_tima;
    cnt_d   = (iMCUwe && sel_div) ? 16'h0000 : cnt_q + 16'd1;
    tac_d   = (iMCUwe && sel_tac) ? iMCUData[2:0] : tac_q;
    tma_d   = (iMCUwe && sel_tma) ? iMCUData : tma_q;
    ie_d    = (iMCUwe && sel_ie) ? iMCUData : ie_q;
    boot_d  = boot_q && !(iMCUwe && sel_bctl && (iMCUData != 8'h00));
    // New cnt/TAC are used so DIV writes and TAC changes can produce an edge.
    tick    = timer_tap(cnt_q, tac_q) && !timer_tap(cnt_d, tac_d);
    ovf     = tick && (tima_q == 8'hFF) && !wr_tima;
    tima_d  = tima_q;
    if (wr_tima)   tima_d = iMCUData;
    else if (tick) tima_d = (tima_q == 8'hFF) ? tma_d : tima_q + 8'd1;
    if_d = if_q;
    if (iMCUwe && sel_if) if_d = iMCUData[4:0];
    if (ovf)              if_d[2] = 1'b1;
  end

  // State registers with asynchronous reset.
  always_ff @(posedge iClock or negedge iReset_n) begin
    if (!iReset_n) begin
      cnt_q   <= 16'h0000;
      tima_q  <= 8'h00;
      tma_q   <= 8'h00;
      tac_q   <= 3'b000;
      if_q    <= 5'b00000;
      ie_q    <= 8'h00;
      boot_q  <= 1'b1;
      rdata_q <= 8'h00;
    end else begin
      cnt_q  <= cnt_d;
      tima_q <= tima_d;
      tma_q  <= tma_d;
      tac_q  <= tac_d;
      if_q   <= if_d;
      ie_q   <= ie_d;
      boot_q <= boot_d;
      if (!iMCUwe) rdata_q <= rdata_d;
    end
  end

  // RAM writes; contents are don't-care across reset so no reset gating.
  always_ff @(posedge iClock) begin
    if (iMCUwe && sel_wram) wram[wram_idx] <= iMCUData;
    if (iMCUwe && sel_hram) hram[hram_idx] <= iMCUData;
  end

endmodule
